issue_arbiter_stage: RTL and testbench
======================================

ISSUE_ARBITER_STAGE -- requirements
Module: issue_arbiter_stage

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of fetch request channels (range 1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the payload width of requests and responses.
REQ-003 SHALL have parameter NUM_IDS, default 4, meaning the number of outstanding transaction IDs (power of 2, range 2..16).
REQ-004 SHALL have parameter PIPELINE_PASSTHROUGH, default 0; when 1, the response output register is bypassed (combinational path).
REQ-005 clk_i  in  1  single clock; all logic is rising-edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 fetch_valid_i / fetch_ready_o / fetch_data_i  in/out/in  NUM_CH / NUM_CH / NUM_CH x DATA_WIDTH  per-channel fetch requests.
REQ-008 be_valid_o / be_ready_i / be_data_o / be_id_o  out/in/out/out  1 / 1 / DATA_WIDTH / clog2(NUM_IDS)  issue to backend.
REQ-009 rsp_valid_i / rsp_ready_o / rsp_data_i / rsp_id_i  in/out/in/in  1 / 1 / DATA_WIDTH / clog2(NUM_IDS)  backend response.
REQ-010 plb_valid_o / plb_ready_i / plb_data_o / plb_ch_o  out/in/out/out  1 / 1 / DATA_WIDTH / clog2(NUM_CH) (min 1)  response to PLB lookup, tagged with the originating channel.
REQ-011 flush_i  in  1  synchronous flush; idle_o  out  1  no IDs outstanding and both output registers empty; err_o  out  1  one-cycle pulse on an unknown-ID response.

Function
REQ-012 SHALL arbitrate fetch channels round-robin; the pointer advances to one past the winner only on a completed fetch handshake.
REQ-013 SHALL assert fetch_ready_o only for the arbitration winner, and only when a free ID exists and the issue register is empty or being drained this cycle.
REQ-014 SHALL allocate the lowest-index free ID on each fetch handshake, record the winner's channel against it, and load data and ID into the issue register; latency is 1 cycle from fetch handshake to be_valid_o.
REQ-015 SHALL hold be_valid_o, be_data_o and be_id_o stable until be_ready_i is sampled high.
REQ-016 SHALL accept a response (rsp_ready_o=1) when the response register is empty or draining; on a handshake with an outstanding ID, load plb_data_o and plb_ch_o from the table and free the ID in the same edge.
REQ-017 SHALL accept and drop a response whose ID is not outstanding, pulse err_o for 1 cycle, and leave the ID table unchanged.
REQ-018 SHALL compute allocation from the free set before that edge's releases; an ID freed and requested in the same cycle is available from the next cycle onward.
REQ-019 SHALL deassert all fetch_ready_o while all NUM_IDS IDs are outstanding; it SHALL issue again the cycle after any release.
REQ-020 SHALL, on flush_i=1, clear both output registers, free all IDs, reset the arbiter pointer to channel 0, and force all ready outputs low that cycle.
REQ-021 SHALL, with PIPELINE_PASSTHROUGH=1, drive plb_* combinationally from rsp_* and the table, with rsp_ready_o=plb_ready_i.

Reset
REQ-022 SHALL, while rst_ni=0, drive be_valid_o=0, plb_valid_o=0, err_o=0, all fetch_ready_o=0, rsp_ready_o=0, idle_o=1, and data/ID/channel outputs to 0.
REQ-023 SHALL, on reset mid-transaction, discard all in-flight state: free all IDs, set pointer=0, empty both registers; the first request after release is granted to the lowest valid channel at or after 0.

Structure
REQ-024 SHALL place the ID/channel width localparams and the outstanding-entry typedef (valid bit plus channel index) in mpt_pkg.
REQ-025 SHALL implement round-robin arbitration as one sub-module, rr_arbiter (parameter NUM_REQ; inputs req and advance; output one-hot grant).

Verification
REQ-026 Channels 0 and 1 valid every cycle, be_ready_i=1 -> grants alternate 0,1,0,1; be_id_o = 0,1,2,3.
REQ-027 NUM_IDS=4, no responses -> after 4 issues all fetch_ready_o=0; response with ID 2 -> next issue carries be_id_o=2 one cycle later.
REQ-028 Response with ID 3 never issued -> err_o high exactly 1 cycle, plb_valid_o stays 0, idle_o unchanged.
REQ-029 plb_ready_i=0 for 5 cycles with a pending response -> plb_data_o and plb_ch_o stable, rsp_ready_o=0 for those cycles.
REQ-030 Two IDs outstanding, flush_i pulse -> next cycle idle_o=1, be_valid_o=0, next issue uses ID 0 from channel 0.
REQ-031 rst_ni asserted mid-issue with be_valid_o=1 -> be_valid_o=0 immediately (asynchronous), idle_o=1.

Source files
------------

// File: rtl/mpt_pkg.sv
// Shared widths, helper function and the outstanding-transaction table entry
// used by the issue arbiter stage.
package mpt_pkg;

  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = $clog2(MAX_CH);

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One outstanding ID: busy flag plus the channel that issued it.
  typedef struct packed {
    logic                valid;
    logic [CH_IDX_W-1:0] ch;
  } ost_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requester at or after the pointer wins; the
// pointer moves to one past the winner only when advance_i is high.
module rr_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PTR_W = idx_width(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] hi_mask, sel;
  logic               found;

  // NOTE: every output of a combinational block gets a default first so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    grant_o = '0;
    win_idx = '0;
    found   = 1'b0;
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(ptr_q));
    end
    sel = (|(req_i & hi_mask)) ? (req_i & hi_mask) : req_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i] && !found) begin
        grant_o[i] = 1'b1;
        win_idx    = PTR_W'(i);
        found      = 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (advance_i) begin
      ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/issue_arbiter_stage.sv
// Fetch issue stage: round-robin picks a channel, tags it with a free ID and
// issues to the backend; responses are matched back to their channel.
module issue_arbiter_stage
  import mpt_pkg::*;
#(
  parameter int NUM_CH               = 2,
  parameter int DATA_WIDTH           = 32,
  parameter int NUM_IDS              = 4,
  parameter bit PIPELINE_PASSTHROUGH = 1'b0,
  localparam int ID_W                = idx_width(NUM_IDS),
  localparam int CH_W                = idx_width(NUM_CH)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_CH-1:0]                fetch_valid_i,
  output logic [NUM_CH-1:0]                fetch_ready_o,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] fetch_data_i,
  output logic                             be_valid_o,
  input  logic                             be_ready_i,
  output logic [DATA_WIDTH-1:0]            be_data_o,
  output logic [ID_W-1:0]                  be_id_o,
  input  logic                             rsp_valid_i,
  output logic                             rsp_ready_o,
  input  logic [DATA_WIDTH-1:0]            rsp_data_i,
  input  logic [ID_W-1:0]                  rsp_id_i,
  output logic                             plb_valid_o,
  input  logic                             plb_ready_i,
  output logic [DATA_WIDTH-1:0]            plb_data_o,
  output logic [CH_W-1:0]                  plb_ch_o,
  input  logic                             flush_i,
  output logic                             idle_o,
  output logic                             err_o
);

  ost_entry_t            table_q [NUM_IDS];
  ost_entry_t            table_d [NUM_IDS];
  ost_entry_t            rsp_entry;
  logic                  be_valid_q, be_valid_d;
  logic [DATA_WIDTH-1:0] be_data_q, be_data_d;
  logic [ID_W-1:0]       be_id_q, be_id_d;
  logic                  plb_valid_q, plb_valid_d;
  logic [DATA_WIDTH-1:0] plb_data_q, plb_data_d;
  logic [CH_W-1:0]       plb_ch_q, plb_ch_d;
  logic                  err_q, err_d;

  logic [NUM_CH-1:0]     grant;
  logic                  run, issue_room, any_free, any_busy;
  logic                  fetch_hs, rsp_hs, rsp_hit;
  logic [ID_W-1:0]       alloc_id;
  logic [CH_W-1:0]       win_ch;
  logic [DATA_WIDTH-1:0] win_data;

  // Ready outputs are gated by reset too, so they read low while held in reset.
  assign run        = rst_ni & ~flush_i;
  assign issue_room = ~be_valid_q | be_ready_i;

  rr_arbiter #(.NUM_REQ(NUM_CH)) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (flush_i),
    .req_i     (fetch_valid_i),
    .advance_i (fetch_hs),
    .grant_o   (grant)
  );

  always_comb begin
    any_free = 1'b0;
    any_busy = 1'b0;
    alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (!table_q[i].valid) begin
        any_free = 1'b1;
        alloc_id = ID_W'(i);
      end else begin
        any_busy = 1'b1;
      end
    end
    win_ch   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        win_ch   = CH_W'(i);
        win_data = fetch_data_i[i];
      end
    end
  end

  assign fetch_ready_o = grant & {NUM_CH{issue_room & any_free & run}};
  assign fetch_hs      = |(fetch_valid_i & fetch_ready_o);
  assign rsp_entry     = table_q[rsp_id_i];
  assign rsp_hit       = rsp_entry.valid;
  assign rsp_hs        = rsp_valid_i & rsp_ready_o;

  // Allocation reads table_q, so an ID released on this edge is only
  // reusable from the next cycle.
  always_comb begin
    table_d     = table_q;
    be_valid_d  = be_valid_q;
    be_data_d   = be_data_q;
    be_id_d     = be_id_q;
    plb_valid_d = plb_valid_q;
    plb_data_d  = plb_data_q;
    plb_ch_d    = plb_ch_q;
    err_d       = 1'b0;

    if (be_valid_q && be_ready_i) be_valid_d = 1'b0;
    if (fetch_hs) begin
      be_valid_d        = 1'b1;
      be_data_d         = win_data;
      be_id_d           = alloc_id;
      table_d[alloc_id] = '{valid: 1'b1, ch: CH_IDX_W'(win_ch)};
    end

    if (plb_valid_q && plb_ready_i) plb_valid_d = 1'b0;
    if (rsp_hs) begin
      if (rsp_hit) begin
        table_d[rsp_id_i].valid = 1'b0;
        if (PIPELINE_PASSTHROUGH == 1'b0) begin
          plb_valid_d = 1'b1;
          plb_data_d  = rsp_data_i;
          plb_ch_d    = CH_W'(rsp_entry.ch);
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (flush_i) begin
      for (int i = 0; i < NUM_IDS; i++) table_d[i] = '0;
      be_valid_d  = 1'b0;
      plb_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  // NOTE: the ID table is a small flop array, not RAM, so it is reset along
  // with the control state; stale busy bits would otherwise leak IDs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_IDS; i++) table_q[i] <= '0;
      be_valid_q  <= 1'b0;
      be_data_q   <= '0;
      be_id_q     <= '0;
      plb_valid_q <= 1'b0;
      plb_data_q  <= '0;
      plb_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      table_q     <= table_d;
      be_valid_q  <= be_valid_d;
      be_data_q   <= be_data_d;
      be_id_q     <= be_id_d;
      plb_valid_q <= plb_valid_d;
      plb_data_q  <= plb_data_d;
      plb_ch_q    <= plb_ch_d;
      err_q       <= err_d;
    end
  end

  assign be_valid_o = be_valid_q;
  assign be_data_o  = be_data_q;
  assign be_id_o    = be_id_q;
  assign err_o      = err_q;
  assign idle_o     = ~any_busy & ~be_valid_q & ~plb_valid_q;

  if (PIPELINE_PASSTHROUGH) begin : g_pass
    assign rsp_ready_o = plb_ready_i & run;
    assign plb_valid_o = rsp_valid_i & rsp_hit & run;
    assign plb_data_o  = rst_ni ? rsp_data_i : '0;
    assign plb_ch_o    = rst_ni ? CH_W'(rsp_entry.ch) : '0;
  end else begin : g_reg
    assign rsp_ready_o = (~plb_valid_q | plb_ready_i) & run;
    assign plb_valid_o = plb_valid_q;
    assign plb_data_o  = plb_data_q;
    assign plb_ch_o    = plb_ch_q;
  end

endmodule

// File: tb/tb_issue_arbiter_stage.sv
// Directed bench for issue_arbiter_stage: a reference model predicts readies,
// and scoreboard queues hold the expected backend issues and PLB responses.
module tb_issue_arbiter_stage;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int NID = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NCH-1:0]          fetch_valid, fetch_ready_o;
  logic [NCH-1:0][DW-1:0]  fetch_data;
  logic                    be_valid_o, be_ready;
  logic [DW-1:0]           be_data_o;
  logic [1:0]              be_id_o;
  logic                    rsp_valid, rsp_ready_o;
  logic [DW-1:0]           rsp_data;
  logic [1:0]              rsp_id;
  logic                    plb_valid_o, plb_ready;
  logic [DW-1:0]           plb_data_o;
  logic                    plb_ch_o;
  logic                    flush, idle_o, err_o;

  always #5 clk = ~clk;

  issue_arbiter_stage #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .NUM_IDS(NID), .PIPELINE_PASSTHROUGH(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data),
    .be_valid_o(be_valid_o), .be_ready_i(be_ready), .be_data_o(be_data_o), .be_id_o(be_id_o),
    .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready_o), .rsp_data_i(rsp_data), .rsp_id_i(rsp_id),
    .plb_valid_o(plb_valid_o), .plb_ready_i(plb_ready), .plb_data_o(plb_data_o), .plb_ch_o(plb_ch_o),
    .flush_i(flush), .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct { logic [DW-1:0] data; logic [1:0] id; } iss_t;
  typedef struct { logic [DW-1:0] data; logic ch; } plb_t;

  iss_t iss_q[$];
  plb_t plb_q[$];
  logic m_busy [NID];
  logic m_ch   [NID];
  int   m_ptr;
  logic m_err;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NID; i++) begin
      m_busy[i] = 1'b0;
      m_ch[i]   = 1'b0;
    end
    m_ptr = 0;
    m_err = 1'b0;
    iss_q.delete();
    plb_q.delete();
  endtask

  // One cycle: compare at the falling edge, then advance the model to the
  // state the DUT will hold after the next rising edge.
  task automatic tick();
    int       win, alloc;
    logic     any_free, hit, exp_rr, idle_exp;
    logic [NCH-1:0] exp_fr;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (win < 0 && fetch_valid[c]) win = c;
    end
    any_free = 1'b0;
    alloc    = 0;
    for (int i = NID - 1; i >= 0; i--) begin
      if (!m_busy[i]) begin
        any_free = 1'b1;
        alloc    = i;
      end
    end
    exp_fr = '0;
    if (!flush && win >= 0 && any_free && (iss_q.size() == 0 || be_ready)) exp_fr[win] = 1'b1;
    exp_rr = !flush && (plb_q.size() == 0 || plb_ready);
    idle_exp = (iss_q.size() == 0) && (plb_q.size() == 0);
    for (int i = 0; i < NID; i++) if (m_busy[i]) idle_exp = 1'b0;

    check("fetch_ready", 64'(fetch_ready_o), 64'(exp_fr));
    check("rsp_ready", 64'(rsp_ready_o), 64'(exp_rr));
    check("err", 64'(err_o), 64'(m_err));
    check("idle", 64'(idle_o), 64'(idle_exp));
    if (iss_q.size() > 0) begin
      check("be_valid", 64'(be_valid_o), 64'd1);
      check("be_data", 64'(be_data_o), 64'(iss_q[0].data));
      check("be_id", 64'(be_id_o), 64'(iss_q[0].id));
    end else begin
      check("be_valid", 64'(be_valid_o), 64'd0);
    end
    if (plb_q.size() > 0) begin
      check("plb_valid", 64'(plb_valid_o), 64'd1);
      check("plb_data", 64'(plb_data_o), 64'(plb_q[0].data));
      check("plb_ch", 64'(plb_ch_o), 64'(plb_q[0].ch));
    end else begin
      check("plb_valid", 64'(plb_valid_o), 64'd0);
    end

    m_err = 1'b0;
    if (flush) begin
      model_reset();
    end else begin
      if (iss_q.size() > 0 && be_ready) void'(iss_q.pop_front());
      hit = m_busy[rsp_id];
      if (exp_fr != '0) begin
        m_busy[alloc] = 1'b1;
        m_ch[alloc]   = win[0];
        iss_q.push_back('{fetch_data[win], 2'(alloc)});
        m_ptr = (win + 1) % NCH;
      end
      if (plb_q.size() > 0 && plb_ready) void'(plb_q.pop_front());
      if (rsp_valid && exp_rr) begin
        if (hit) begin
          plb_q.push_back('{rsp_data, m_ch[rsp_id]});
          m_busy[rsp_id] = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int n);
    fetch_data[0] = 32'hA000_0000 + 32'(n);
    fetch_data[1] = 32'hB000_0000 + 32'(n);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    fetch_valid = 2'b11; set_data(0); be_ready = 1'b1;
    rsp_valid = 1'b1; rsp_data = '0; rsp_id = 2'd0; plb_ready = 1'b1;
    model_reset();

    // Reset values while inputs are active
    #12;
    check("rst_be_valid", 64'(be_valid_o), 64'd0);
    check("rst_plb_valid", 64'(plb_valid_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_fetch_ready", 64'(fetch_ready_o), 64'd0);
    check("rst_rsp_ready", 64'(rsp_ready_o), 64'd0);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_be_data", 64'(be_data_o), 64'd0);
    check("rst_be_id", 64'(be_id_o), 64'd0);
    check("rst_plb_data", 64'(plb_data_o), 64'd0);
    check("rst_plb_ch", 64'(plb_ch_o), 64'd0);
    fetch_valid = '0; rsp_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Alternating grants, IDs 0..3, then stall with every ID outstanding
    fetch_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      set_data(n);
      tick();
      if (n < 4) begin
        check("seq_id", 64'(be_id_o), 64'(n));
        check("seq_data", 64'(be_data_o), (n % 2 == 0) ? 64'(32'hA000_0000 + 32'(n))
                                                        : 64'(32'hB000_0000 + 32'(n)));
      end
    end

    // Releasing ID 2 lets the next issue reuse it
    rsp_valid = 1'b1; rsp_id = 2'd2; rsp_data = 32'hD2D2_0002;
    set_data(6);
    tick();
    rsp_valid = 1'b0;
    set_data(7);
    tick();
    check("reuse_valid", 64'(be_valid_o), 64'd1);
    check("reuse_id", 64'(be_id_o), 64'd2);
    tick();

    // Backpressured PLB: response held for five cycles
    fetch_valid = '0; plb_ready = 1'b0;
    rsp_valid = 1'b1; rsp_id = 2'd0; rsp_data = 32'hD0D0_0000;
    tick();
    rsp_id = 2'd1; rsp_data = 32'hD1D1_0001;
    for (int n = 0; n < 5; n++) tick();
    plb_ready = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    tick();

    // Unknown ID: err pulse, response dropped
    rsp_valid = 1'b1; rsp_id = 2'd0; rsp_data = 32'hEEEE_EEEE;
    tick();
    rsp_valid = 1'b0;
    tick();
    tick();

    // Flush with IDs 2 and 3 outstanding
    flush = 1'b1; fetch_valid = 2'b11; set_data(8);
    tick();
    flush = 1'b0; set_data(9);
    tick();
    check("flush_id", 64'(be_id_o), 64'd0);
    check("flush_data", 64'(be_data_o), 64'(32'hA000_0009));

    // Asynchronous reset while an issue is held
    fetch_valid = '0; be_ready = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_be_valid", 64'(be_valid_o), 64'd0);
    check("arst_idle", 64'(idle_o), 64'd1);
    check("arst_fetch_ready", 64'(fetch_ready_o), 64'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    be_ready = 1'b1; fetch_valid = 2'b10; set_data(10);
    tick();
    check("post_rst_id", 64'(be_id_o), 64'd0);
    check("post_rst_data", 64'(be_data_o), 64'(32'hB000_000A));
    fetch_valid = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
